kicp_sram_arbiter: RTL and testbench
====================================

// Module: kicp_sram_arbiter
// PURPOSE
//  N-requester arbitrated controller for the single-port KICP SRAM macro. Wishbone DMA, matrix-mul,
//  matrix-conv and future cores each get a valid/ready request port and a response strobe.
//  Round-robin grant, byte-enable writes, fixed read latency.
//  Sits between the compute cores and the SRAM macro in the KICP user area.
// PARAMETERS
//  NUM_REQ     3   number of requester ports (>=2); port 0 is the Wishbone DMA
//  AWIDTH      8   SRAM word-address width
//  DWIDTH      32  data width; must be a multiple of 8
//  RD_LATENCY  1   cycles from the sram_en cycle to valid sram_data_o (>=1)
// PORTS
//  clk          in   1               clock, all logic on rising edge
//  reset_n      in   1               asynchronous active-low reset
//  req_valid    in   NUM_REQ         per-port request valid
//  req_ready    out  NUM_REQ         per-port accept; at most one bit high, only in IDLE
//  req_we       in   NUM_REQ         per-port 1=write, 0=read
//  req_be       in   NUM_REQ*DWIDTH/8  byte enables, port i at [i*DWIDTH/8 +: DWIDTH/8]
//  req_addr     in   NUM_REQ*AWIDTH  word address, port i at [i*AWIDTH +: AWIDTH]
//  req_wdata    in   NUM_REQ*DWIDTH  write data, port i at [i*DWIDTH +: DWIDTH]
//  rsp_valid    out  NUM_REQ         one-cycle completion pulse to the granted port
//  rsp_rdata    out  DWIDTH          read data; valid with rsp_valid of a read
//  busy         out  1               high in every state except IDLE
//  sram_en      out  1               SRAM chip enable
//  sram_we      out  DWIDTH/8        SRAM byte write enables
//  sram_addr    out  AWIDTH          SRAM address
//  sram_data_i  out  DWIDTH          SRAM write data
//  sram_data_o  in   DWIDTH          SRAM read data
// BEHAVIOUR
//  - Reset (async, reset_n=0): every output is 0, including rsp_rdata, sram_addr and sram_data_i.
//    FSM goes to IDLE and the RR pointer goes to NUM_REQ-1. Any in-flight op is dropped with no rsp_valid.
//  - FSM: IDLE -> ISSUE -> (read: WAIT x RD_LATENCY) -> RESP -> IDLE. One transaction in flight.
//  - IDLE: req_ready[g] is asserted combinationally for the winner g among req_valid.
//    A handshake is valid && ready in cycle T. It latches g, we, be, addr and wdata.
//    It sets pointer=g and moves to ISSUE. With no req_valid the FSM stays in IDLE with req_ready=0.
//  - Round-robin: search starts at pointer+1 and wraps modulo NUM_REQ.
//    Pointer NUM_REQ-1 wraps to 0.
//  - ISSUE (T+1): sram_en=1, sram_addr=latched addr.
//    For a write: sram_we=latched be, sram_data_i=wdata. For a read: sram_we=0.
//    sram_en and sram_we are 0 in all other states. sram_addr and sram_data_i hold their last value.
//  - WAIT (reads only): count RD_LATENCY cycles.
//    sram_data_o is captured into rsp_rdata at the edge ending the last WAIT cycle.
//  - RESP: rsp_valid[g]=1 for exactly one cycle; there is no backpressure.
//    Write response: T+2. Read response: T+2+RD_LATENCY.
//    rsp_rdata holds until the next read capture; writes leave it unchanged.
//  - Write with be=0: a full cycle is still issued (sram_en=1, sram_we=0) and rsp_valid is returned.
//  - req_valid may drop before the handshake; there is no commitment until valid && ready.
//    Request inputs are ignored outside IDLE.
//  - Simultaneous requests: exactly one grant per IDLE cycle.
//    Losers keep valid asserted and are served in round-robin order, so no port waits more than NUM_REQ-1 grants.
// CONFIGURATION
//  KICP_MEMCTL_WB_PRIO_EN
//  - defined: port 0 has absolute priority whenever req_valid[0]=1, and a port-0 grant does not move the pointer.
//    Ports 1..NUM_REQ-1 stay round-robin among themselves.
//  - undefined: all NUM_REQ ports are pure round-robin as above.
// STRUCTURE
//  - Shared header kicp_memctl_defines.vh holds:
//    - state encodings `KICP_MC_IDLE/ISSUE/WAIT/RESP (2 bits);
//    - the default `KICP_SRAM_AWIDTH used for AWIDTH.
//  - Sub-module kicp_rr_arbiter (params NUM_REQ; in req, pointer; out one-hot grant, grant index)
//    is purely combinational and reused by future arbiters.
//  - Top holds the FSM, latency counter, latch registers and output muxing.
// TESTING
//  1 Reset: reset_n=0 mid-read (in WAIT) -> all outputs 0 immediately, and no rsp_valid after release.
//    Then a read from port 1 at addr 0x05 completes normally.
//  2 Write then read with RD_LATENCY=1, port 0:
//    write addr 0x10, data 0xDEADBEEF, be=4'hF -> rsp_valid[0] at T+2.
//    Read of 0x10 -> rsp_rdata=0xDEADBEEF at T+3.
//  3 Byte enables: write 0xFFFFFFFF then 0x00000000 with be=4'b0101 to 0x20 -> read returns 0xFF00FF00.
//    be=0 write -> rsp_valid returned, memory unchanged.
//  4 Round-robin: all 3 ports hold req_valid from reset -> grant order 0,1,2,0,1,2.
//    Each port gets exactly one rsp_valid per 3 transactions.
//  5 With KICP_MEMCTL_WB_PRIO_EN defined and ports 0..2 continuously valid -> port 0 is always granted.
//    Drop port 0 -> order 1,2,1,2.
//  6 RD_LATENCY=3: read 0x33 -> sram_en is high for one cycle, rsp_valid at T+5, data matches the model.
//    busy stays high T+1..T+5.

Source files
------------

// File: rtl/kicp_sram_arbiter_pkg.sv
// Shared definitions for the KICP SRAM arbiter: controller state encoding,
// default SRAM address width and an index-width helper.
package kicp_sram_arbiter_pkg;

  localparam int unsigned KICP_SRAM_AWIDTH = 8;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_ISSUE = 2'd1,
    MC_WAIT  = 2'd2,
    MC_RESP  = 2'd3
  } mc_state_e;

  // Width of an index into n items; never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kicp_sram_arbiter_rr.sv
// kicp_rr_arbiter: combinational round-robin picker. The search starts one past
// the pointer and wraps modulo NUM_REQ; outputs a one-hot grant and its index.
module kicp_rr_arbiter
  import kicp_sram_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((32'(pointer) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/kicp_sram_arbiter.sv
// N-requester round-robin controller for the single-port KICP SRAM macro.
// Optional build macro KICP_MEMCTL_WB_PRIO_EN gives port 0 absolute priority.
module kicp_sram_arbiter
  import kicp_sram_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned AWIDTH     = KICP_SRAM_AWIDTH,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*(DWIDTH/8)-1:0] req_be,
  input  logic [NUM_REQ*AWIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DWIDTH-1:0]             rsp_rdata,
  output logic                          busy,
  output logic                          sram_en,
  output logic [DWIDTH/8-1:0]           sram_we,
  output logic [AWIDTH-1:0]             sram_addr,
  output logic [DWIDTH-1:0]             sram_data_i,
  input  logic [DWIDTH-1:0]             sram_data_o
);

  localparam int unsigned BW = DWIDTH / 8;
  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned CW = idx_width(RD_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY - 1);

  mc_state_e           state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [BW-1:0]       be_q, be_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;

  logic [NUM_REQ-1:0]  arb_req, arb_grant, win_grant;
  logic [IW-1:0]       arb_idx, win_idx;
  logic                ptr_upd;

  logic                sel_we;
  logic [BW-1:0]       sel_be;
  logic [AWIDTH-1:0]   sel_addr;
  logic [DWIDTH-1:0]   sel_wdata;

  kicp_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (arb_req),
    .pointer   (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef KICP_MEMCTL_WB_PRIO_EN
  // Port 0 bypasses the rotation; the others rotate among themselves and
  // a port-0 grant leaves the pointer where it was.
  assign arb_req   = {req_valid[NUM_REQ-1:1], 1'b0};
  assign win_grant = req_valid[0] ? NUM_REQ'(1) : arb_grant;
  assign win_idx   = req_valid[0] ? '0 : arb_idx;
  assign ptr_upd   = ~req_valid[0];
`else
  assign arb_req   = req_valid;
  assign win_grant = arb_grant;
  assign win_idx   = arb_idx;
  assign ptr_upd   = 1'b1;
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        sel_we    = req_we[i];
        sel_be    = req_be[i*BW +: BW];
        sel_addr  = req_addr[i*AWIDTH +: AWIDTH];
        sel_wdata = req_wdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      MC_IDLE: begin
        if (|win_grant) begin
          state_d = MC_ISSUE;
          gnt_d   = win_grant;
          we_d    = sel_we;
          be_d    = sel_be;
          addr_d  = sel_addr;
          // Write data only moves on writes so sram_data_i keeps its last value.
          if (sel_we) wdata_d = sel_wdata;
          if (ptr_upd) ptr_d = win_idx;
        end
      end
      MC_ISSUE: begin
        cnt_d   = '0;
        state_d = we_q ? MC_RESP : MC_WAIT;
      end
      MC_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d = sram_data_o;
          state_d = MC_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MC_RESP: state_d = MC_IDLE;
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      gnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready   = (state_q == MC_IDLE) ? win_grant : '0;
  assign rsp_valid   = (state_q == MC_RESP) ? gnt_q : '0;
  assign rsp_rdata   = rdata_q;
  assign busy        = (state_q != MC_IDLE);
  assign sram_en     = (state_q == MC_ISSUE);
  assign sram_we     = (state_q == MC_ISSUE && we_q) ? be_q : '0;
  assign sram_addr   = addr_q;
  assign sram_data_i = wdata_q;

endmodule

// File: tb/tb_kicp_sram_arbiter.sv
// Directed bench for kicp_sram_arbiter: one instance with RD_LATENCY=1, one with 3,
// each attached to a behavioural SRAM preloaded with {4{addr}}.
module tb_kicp_sram_arbiter;

  localparam int NR = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic reset_n;

  logic [NR-1:0]    req_valid [2];
  logic [NR-1:0]    req_ready [2];
  logic [NR-1:0]    req_we    [2];
  logic [NR*BW-1:0] req_be    [2];
  logic [NR*AW-1:0] req_addr  [2];
  logic [NR*DW-1:0] req_wdata [2];
  logic [NR-1:0]    rsp_valid [2];
  logic [DW-1:0]    rsp_rdata [2];
  logic             busy      [2];
  logic             sram_en   [2];
  logic [BW-1:0]    sram_we   [2];
  logic [AW-1:0]    sram_addr [2];
  logic [DW-1:0]    sram_data_i [2];
  logic [DW-1:0]    sram_data_o [2];

  always #5 clk = ~clk;

  kicp_sram_arbiter #(.NUM_REQ(NR), .AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(1)) dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .sram_en(sram_en[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
    .sram_data_i(sram_data_i[0]), .sram_data_o(sram_data_o[0])
  );

  kicp_sram_arbiter #(.NUM_REQ(NR), .AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(3)) dut_l3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .sram_en(sram_en[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
    .sram_data_i(sram_data_i[1]), .sram_data_o(sram_data_o[1])
  );

  for (genvar d = 0; d < 2; d++) begin : g_mem
    localparam int L = (d == 0) ? 1 : 3;
    logic [DW-1:0] mem  [256];
    logic [DW-1:0] pipe [L];
    initial for (int a = 0; a < 256; a++) mem[a] = {4{8'(a)}};
    always @(posedge clk) begin
      if (sram_en[d]) begin
        for (int b = 0; b < BW; b++)
          if (sram_we[d][b]) mem[sram_addr[d]][b*8 +: 8] <= sram_data_i[d][b*8 +: 8];
        pipe[0] <= mem[sram_addr[d]];
      end
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign sram_data_o[d] = pipe[L-1];
  end

  int n_pass = 0;
  int n_tot  = 0;
  int rc [NR];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input int d, input string nm);
    chk({nm, " ctl"}, {16'h0, req_ready[d], rsp_valid[d], busy[d], sram_en[d], sram_we[d]}, 32'h0);
    chk({nm, " rdata"}, rsp_rdata[d], 32'h0);
    chk({nm, " addr"}, 32'(sram_addr[d]), 32'h0);
    chk({nm, " wdata"}, sram_data_i[d], 32'h0);
  endtask

  task automatic acc(input int d);
    for (int i = 0; i < NR; i++) if (rsp_valid[d][i]) rc[i]++;
  endtask

  // One complete transaction; latency is counted from the handshake cycle T.
  task automatic txn(input string nm, input int d, input int p, input logic we,
                     input logic [3:0] be, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input int exp_lat);
    int n, lat, en_cnt, busy_cnt;
    logic [3:0] we_seen;
    logic [7:0] addr_seen;
    req_we[d][p]          = we;
    req_be[d][p*BW +: BW] = be;
    req_addr[d][p*AW +: AW] = addr;
    req_wdata[d][p*DW +: DW] = wdata;
    req_valid[d][p]       = 1'b1;
    #1;
    n = 0;
    while (!req_ready[d][p] && n < 50) begin step(); n++; end
    chk({nm, " handshake"}, 32'(req_ready[d]), 32'(1 << p));
    chk({nm, " idle busy"}, 32'(busy[d]), 32'h0);
    step();
    req_valid[d][p] = 1'b0;
    lat = 1; en_cnt = 0; busy_cnt = 0; we_seen = '0; addr_seen = '0;
    while (!rsp_valid[d][p] && lat < 50) begin
      if (sram_en[d]) begin en_cnt++; we_seen = sram_we[d]; addr_seen = sram_addr[d]; end
      if (busy[d]) busy_cnt++;
      step();
      lat++;
    end
    if (sram_en[d]) en_cnt++;
    if (busy[d]) busy_cnt++;
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " rsp_valid"}, 32'(rsp_valid[d]), 32'(1 << p));
    chk({nm, " rdata"}, rsp_rdata[d], exp_rd);
    chk({nm, " en cycles"}, 32'(en_cnt), 32'd1);
    chk({nm, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({nm, " sram_we"}, 32'(we_seen), we ? 32'(be) : 32'h0);
    chk({nm, " sram_addr"}, 32'(addr_seen), 32'(addr));
    step();
    chk({nm, " rsp one-shot"}, {29'h0, rsp_valid[d]} | {31'h0, busy[d]}, 32'h0);
  endtask

  typedef struct {
    int          d;
    int          p;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{0, 0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h00000000, 2};
    vt[1]  = '{0, 0, 1'b0, 4'h0, 8'h10, 32'h0,        32'hDEADBEEF, 3};
    vt[2]  = '{0, 2, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF, 32'hDEADBEEF, 2};
    vt[3]  = '{0, 2, 1'b1, 4'h5, 8'h20, 32'h00000000, 32'hDEADBEEF, 2};
    vt[4]  = '{0, 2, 1'b0, 4'h0, 8'h20, 32'h0,        32'hFF00FF00, 3};
    vt[5]  = '{0, 1, 1'b1, 4'h0, 8'h20, 32'h12345678, 32'hFF00FF00, 2};
    vt[6]  = '{0, 1, 1'b0, 4'h0, 8'h20, 32'h0,        32'hFF00FF00, 3};
    vt[7]  = '{0, 0, 1'b1, 4'h8, 8'h40, 32'hA5A5A5A5, 32'hFF00FF00, 2};
    vt[8]  = '{0, 0, 1'b0, 4'h0, 8'h40, 32'h0,        32'hA5404040, 3};
    vt[9]  = '{1, 1, 1'b0, 4'h0, 8'h33, 32'h0,        32'h33333333, 5};
    vt[10] = '{1, 2, 1'b1, 4'h3, 8'h34, 32'hCAFEF00D, 32'h33333333, 2};
    vt[11] = '{1, 0, 1'b0, 4'h0, 8'h34, 32'h0,        32'h3434F00D, 5};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0; req_we[d] = '0; req_be[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0;
    end
    reset_n = 1'b0;
    step(); step();
    chk_quiet(0, "reset l1");
    chk_quiet(1, "reset l3");
    reset_n = 1'b1;
    step();
    chk("idle no req", {30'h0, busy[0], |req_ready[0]}, 32'h0);

    for (int i = 0; i < 12; i++)
      txn($sformatf("vec%0d", i), vt[i].d, vt[i].p, vt[i].we, vt[i].be, vt[i].addr,
          vt[i].wdata, vt[i].exp_rd, vt[i].exp_lat);

    // Reset while a read sits in WAIT: everything drops at once, no late response.
    begin
      int n;
      req_we[0][1] = 1'b0;
      req_addr[0][1*AW +: AW] = 8'h05;
      req_valid[0][1] = 1'b1;
      #1;
      n = 0;
      while (!req_ready[0][1] && n < 50) begin step(); n++; end
      step();
      req_valid[0][1] = 1'b0;
      step();
      chk("pre-reset in WAIT", {30'h0, busy[0], sram_en[0]}, 32'h2);
      reset_n = 1'b0;
      #1;
      chk_quiet(0, "async reset");
      step(); step();
      reset_n = 1'b1;
      rc = '{0, 0, 0};
      for (int k = 0; k < 6; k++) begin acc(0); step(); end
      chk("no rsp after reset", 32'(rc[0] + rc[1] + rc[2]), 32'h0);
    end
    txn("post-reset read", 0, 1, 1'b0, 4'h0, 8'h05, 32'h0, 32'h05050505, 3);

    // All three ports held valid from reset.
    begin
      int n;
      logic [2:0] exp_g;
      reset_n = 1'b0;
      for (int p = 0; p < NR; p++) begin
        req_we[0][p] = 1'b0;
        req_addr[0][p*AW +: AW] = 8'(p + 1);
      end
      req_valid[0] = 3'b111;
      step();
      reset_n = 1'b1;
      #1;
      rc = '{0, 0, 0};
`ifdef KICP_MEMCTL_WB_PRIO_EN
      for (int k = 0; k < 7; k++) begin
        n = 0;
        while (req_ready[0] == '0 && n < 20) begin acc(0); step(); n++; end
        exp_g = (k < 3) ? 3'b001 : ((k % 2 == 1) ? 3'b010 : 3'b100);
        chk($sformatf("prio grant %0d", k), 32'(req_ready[0]), 32'(exp_g));
        acc(0);
        step();
        if (k == 2) req_valid[0][0] = 1'b0;
      end
`else
      for (int k = 0; k < 6; k++) begin
        n = 0;
        while (req_ready[0] == '0 && n < 20) begin acc(0); step(); n++; end
        exp_g = 3'(1 << (k % 3));
        chk($sformatf("rr grant %0d", k), 32'(req_ready[0]), 32'(exp_g));
        acc(0);
        step();
      end
`endif
      req_valid[0] = '0;
      n = 0;
      while (busy[0] && n < 20) begin acc(0); step(); n++; end
`ifdef KICP_MEMCTL_WB_PRIO_EN
      chk("prio rsp count p0", 32'(rc[0]), 32'd3);
`else
      chk("rr rsp count p0", 32'(rc[0]), 32'd2);
`endif
      chk("rr rsp count p1", 32'(rc[1]), 32'd2);
      chk("rr rsp count p2", 32'(rc[2]), 32'd2);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
